recirculacion_multilane: RTL

//  Parametrised successor of the single-lane Flops/recirculation stage: LANES independent DATA_W-bit lanes.

---
 rtl/recirculacion_multilane_pkg.sv | 16 +
 rtl/recirculacion_multilane_lane.sv | 67 ++++++
 rtl/recirculacion_multilane.sv | 106 ++++++++++
 3 files changed

// File: rtl/recirculacion_multilane_pkg.sv
// Shared definitions for the multilane recirculation stage: link FSM encoding
// and the hold-counter width helper.
package recirculacion_multilane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2
  } link_state_t;

  // Hold counter must represent values up to act_hold-1; +1 keeps width >= 1.
  function automatic int hold_width(input int act_hold);
    return $clog2(act_hold + 1);
  endfunction

endpackage

// File: rtl/recirculacion_multilane_lane.sv
// One lane of the recirculation stage: routes a valid word to the forward or
// recirculation register. Optional saturating counter under RECIR_COUNT_EN.
module recir_lane #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              route_fwd,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_recir,
  output logic [DATA_W-1:0] data_recir
`ifdef RECIR_COUNT_EN
  ,
  output logic [CNT_W-1:0]  recir_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("recir_lane: CNT_W must be >= 1");
  end

  logic              valid_out_reg, valid_recir_reg;
  logic [DATA_W-1:0] data_out_reg, data_recir_reg;
  logic              fwd_hit, recir_hit;

  assign fwd_hit   = valid_in && route_fwd;
  assign recir_hit = valid_in && !route_fwd;

  // Idle lanes are zeroed rather than holding the previous word.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_reg   <= 1'b0;
      data_out_reg    <= '0;
      valid_recir_reg <= 1'b0;
      data_recir_reg  <= '0;
    end else begin
      valid_out_reg   <= fwd_hit;
      data_out_reg    <= fwd_hit ? data_in : '0;
      valid_recir_reg <= recir_hit;
      data_recir_reg  <= recir_hit ? data_in : '0;
    end
  end

  assign valid_out   = valid_out_reg;
  assign data_out    = data_out_reg;
  assign valid_recir = valid_recir_reg;
  assign data_recir  = data_recir_reg;

`ifdef RECIR_COUNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (recir_hit && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign recir_cnt = cnt_reg;
`endif

endmodule

// File: rtl/recirculacion_multilane.sv
// Multilane recirculation stage: link-activity FSM qualifies 'active' over
// ACT_HOLD cycles and steers every lane. Optional counters: RECIR_COUNT_EN.
module recirculacion_multilane
  import recirculacion_multilane_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LANES    = 4,
  parameter int ACT_HOLD = 2,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic [LANES-1:0]        valid_in,
  input  logic [LANES*DATA_W-1:0] data_in,
  output logic [LANES-1:0]        valid_out,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [LANES-1:0]        valid_recir,
  output logic [LANES*DATA_W-1:0] data_recir,
  output logic [1:0]              link_state
`ifdef RECIR_COUNT_EN
  ,
  output logic [LANES*CNT_W-1:0]  recir_cnt
`endif
);

  localparam int HOLD_W = hold_width(ACT_HOLD);

  if (LANES < 1 || ACT_HOLD < 1) begin : g_bad_params
    $error("recirculacion_multilane: LANES and ACT_HOLD must be >= 1");
  end

  link_state_t       state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              route_fwd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (active) begin
          state_next    = (ACT_HOLD == 1) ? ST_ACTIVE : ST_ARM;
          hold_cnt_next = HOLD_W'(1);
        end
      end
      ST_ARM: begin
        if (!active) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_W'(ACT_HOLD - 1)) begin
          state_next    = ST_ACTIVE;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (!active) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Routing follows the registered state, so a word arriving as active drops
  // in ACTIVE is still forwarded.
  assign route_fwd  = (state_reg == ST_ACTIVE);
  assign link_state = state_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    recir_lane #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .route_fwd   (route_fwd),
      .valid_in    (valid_in[gi]),
      .data_in     (data_in[gi*DATA_W +: DATA_W]),
      .valid_out   (valid_out[gi]),
      .data_out    (data_out[gi*DATA_W +: DATA_W]),
      .valid_recir (valid_recir[gi]),
      .data_recir  (data_recir[gi*DATA_W +: DATA_W])
`ifdef RECIR_COUNT_EN
      ,
      .recir_cnt   (recir_cnt[gi*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
